// File: rtl/if_stage_fetchq.sv
// Instruction fetch stage: issues imem reads against queue credit and buffers {pc, instr} for decode.
// Head is valid MEM_LAT+1 cycles after issue. When decode stalls, issue stops once queue + in-flight reads fill FQ_DEPTH.
module if_stage_fetchq #(
  parameter int          ADDR_W   = 10,
  parameter int          MEM_LAT  = 1,
  parameter int          FQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] TRAP_VEC = 32'h100
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         redirect_i,
  input  logic [31:0]                  redirect_pc_i,
  input  logic                         flush_i,
  output logic                         imem_req_o,
  output logic [ADDR_W-1:0]            imem_addr_o,
  input  logic [31:0]                  imem_rdata_i,
  output logic                         instr_valid_o,
  input  logic                         instr_ready_i,
  output logic [31:0]                  pc_o,
  output logic [31:0]                  instr_o,
  output logic [$clog2(FQ_DEPTH+1)-1:0] fq_count_o
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = $clog2(FQ_DEPTH+1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FQ_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W+1)'(FQ_DEPTH);

  logic [31:0]        fetch_pc;
  logic [MEM_LAT-1:0] pipe_vld;
  logic [31:0]        pipe_pc [MEM_LAT];
  logic [31:0]        q_pc    [FQ_DEPTH];
  logic [31:0]        q_instr [FQ_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W:0]     inflight;
  logic [CNT_W:0]     occupancy;
  logic               restart;
  logic [31:0]        restart_pc;
  logic               issue;
  logic               enq;
  logic               deq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      inflight = inflight + (CNT_W+1)'(pipe_vld[i]);
    end
  end

  // Credit uses registered occupancy only; a same-cycle dequeue does not free a slot.
  assign occupancy  = {1'b0, count} + inflight;
  assign restart    = flush_i | redirect_i;
  assign restart_pc = flush_i ? TRAP_VEC : (redirect_pc_i & ~32'h3);
  assign issue      = rst_ni && !restart && (occupancy < DEPTH_C);
  assign enq        = pipe_vld[MEM_LAT-1];
  assign deq        = instr_valid_o && instr_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_pc <= RESET_PC;
      pipe_vld <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (restart) begin
      // Older in-flight returns and queued entries are dropped.
      fetch_pc <= restart_pc;
      pipe_vld <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (issue) fetch_pc <= fetch_pc + 32'd4;
      pipe_vld[0] <= issue;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
      if (enq) wr_ptr <= ptr_inc(wr_ptr);
      if (deq) rd_ptr <= ptr_inc(rd_ptr);
      if (enq && !deq)      count <= count + 1'b1;
      else if (!enq && deq) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    pipe_pc[0] <= fetch_pc;
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_pc[i] <= pipe_pc[i-1];
    end
    if (enq) begin
      q_pc[wr_ptr]    <= pipe_pc[MEM_LAT-1];
      q_instr[wr_ptr] <= imem_rdata_i;
    end
  end

  assign imem_req_o    = issue;
  assign imem_addr_o   = fetch_pc[ADDR_W+1:2];
  assign instr_valid_o = (count != '0);
  assign pc_o          = instr_valid_o ? q_pc[rd_ptr] : 32'h0;
  assign instr_o       = instr_valid_o ? q_instr[rd_ptr] : 32'h0;
  assign fq_count_o    = count;

endmodule

// File: tb/tb_if_stage_fetchq.sv
// Directed bench for if_stage_fetchq: default instance plus a MEM_LAT=2 / ADDR_W=8 instance.
module tb_if_stage_fetchq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redir, flush, rdy;
  logic [31:0] redir_pc;
  logic        req1, vld1;
  logic [9:0]  addr1;
  logic [31:0] rdata1, pc1, ins1;
  logic [2:0]  cnt1;
  logic        redir2, flush2, rdy2;
  logic [31:0] redir_pc2;
  logic        req2, vld2;
  logic [7:0]  addr2;
  logic [31:0] rdata2, stage2, pc2, ins2;
  logic [2:0]  cnt2;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  if_stage_fetchq dut (
    .clk_i(clk), .rst_ni(rst_n), .redirect_i(redir), .redirect_pc_i(redir_pc), .flush_i(flush),
    .imem_req_o(req1), .imem_addr_o(addr1), .imem_rdata_i(rdata1),
    .instr_valid_o(vld1), .instr_ready_i(rdy), .pc_o(pc1), .instr_o(ins1), .fq_count_o(cnt1)
  );

  if_stage_fetchq #(.ADDR_W(8), .MEM_LAT(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .redirect_i(redir2), .redirect_pc_i(redir_pc2), .flush_i(flush2),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_rdata_i(rdata2),
    .instr_valid_o(vld2), .instr_ready_i(rdy2), .pc_o(pc2), .instr_o(ins2), .fq_count_o(cnt2)
  );

  // imem word k holds 32'h1000_0000 | k; unrequested reads return garbage.
  always @(posedge clk) rdata1 <= req1 ? (32'h1000_0000 | {22'd0, addr1}) : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    stage2 <= req2 ? (32'h1000_0000 | {24'd0, addr2}) : 32'hDEAD_BEEF;
    rdata2 <= stage2;
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic r);
    rst_n = 1'b0; rdy = r; rdy2 = 1'b1;
    redir = 1'b0; flush = 1'b0; redir_pc = 32'h0;
    redir2 = 1'b0; flush2 = 1'b0; redir_pc2 = 32'h0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rdy = 1'b1; rdy2 = 1'b1;
    redir = 1'b0; flush = 1'b0; redir_pc = 32'h0;
    redir2 = 1'b0; flush2 = 1'b0; redir_pc2 = 32'h0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_total++; if (vld1 !== 1'b0) $display("FAIL reset_vld got %0b want 0", vld1); else n_pass++;
    n_total++; if (req1 !== 1'b0) $display("FAIL reset_req got %0b want 0", req1); else n_pass++;
    n_total++; if (cnt1 !== 3'd0) $display("FAIL reset_cnt got %0d want 0", cnt1); else n_pass++;
    n_total++; if (pc1 !== 32'h0) $display("FAIL reset_pc got %h want 0", pc1); else n_pass++;
    n_total++; if (ins1 !== 32'h0) $display("FAIL reset_instr got %h want 0", ins1); else n_pass++;
    n_total++; if (vld2 !== 1'b0 || req2 !== 1'b0) $display("FAIL reset2 got vld=%0b req=%0b want 0/0", vld2, req2); else n_pass++;
  endtask

  task automatic test_stream;
    logic [31:0] e;
    do_reset(1'b1);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_total++; if (req1 !== 1'b1 || addr1 !== 10'd0) $display("FAIL stream_first_req got req=%0b addr=%h want 1/0", req1, addr1); else n_pass++;
      end
      if (c == 1) begin
        n_total++; if (vld1 !== 1'b0) $display("FAIL stream_vld_c1 got %0b want 0", vld1); else n_pass++;
      end
      if (c >= 2) begin
        e = 32'(4 * (c - 2));
        n_total++; if (vld1 !== 1'b1 || pc1 !== e) $display("FAIL stream_pc c=%0d got vld=%0b pc=%h want 1/%h", c, vld1, pc1, e); else n_pass++;
        n_total++; if (ins1 !== (32'h1000_0000 | (e >> 2))) $display("FAIL stream_instr c=%0d got %h want %h", c, ins1, 32'h1000_0000 | (e >> 2)); else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] e;
    do_reset(1'b0);
    for (int c = 0; c < 16; c++) begin
      rdy = (c >= 8);
      @(negedge clk);
      if (c == 4) begin
        n_total++; if (cnt1 !== 3'd3 || req1 !== 1'b0) $display("FAIL bp_credit got cnt=%0d req=%0b want 3/0", cnt1, req1); else n_pass++;
      end
      if (c >= 5 && c <= 7) begin
        n_total++; if (cnt1 !== 3'd4 || req1 !== 1'b0) $display("FAIL bp_full c=%0d got cnt=%0d req=%0b want 4/0", c, cnt1, req1); else n_pass++;
        n_total++; if (vld1 !== 1'b1 || pc1 !== 32'h0) $display("FAIL bp_hold c=%0d got vld=%0b pc=%h want 1/0", c, vld1, pc1); else n_pass++;
      end
      if (c == 8) begin
        n_total++; if (req1 !== 1'b0) $display("FAIL bp_full_deq_req got %0b want 0", req1); else n_pass++;
      end
      if (c == 9) begin
        n_total++; if (req1 !== 1'b1 || addr1 !== 10'd4 || cnt1 !== 3'd3) $display("FAIL bp_resume got req=%0b addr=%h cnt=%0d want 1/4/3", req1, addr1, cnt1); else n_pass++;
      end
      if (c >= 8) begin
        e = 32'(4 * (c - 8));
        n_total++; if (vld1 !== 1'b1 || pc1 !== e || ins1 !== (32'h1000_0000 | (e >> 2))) $display("FAIL bp_stream c=%0d got vld=%0b pc=%h instr=%h want 1/%h", c, vld1, pc1, ins1, e); else n_pass++;
      end
      next_cycle();
    end
    rdy = 1'b1;
  endtask

  task automatic test_redirect(input logic use_flush);
    logic [31:0] tgt;
    tgt = use_flush ? 32'h100 : 32'h40;
    do_reset(1'b1);
    for (int c = 0; c < 11; c++) begin
      redir = (c == 5);
      flush = (c == 5) && use_flush;
      redir_pc = (c == 5) ? (use_flush ? 32'h80 : 32'h43) : 32'h0;
      @(negedge clk);
      if (c == 5) begin
        n_total++; if (req1 !== 1'b0 || vld1 !== 1'b1 || pc1 !== 32'hC) $display("FAIL redir_cycle f=%0b got req=%0b vld=%0b pc=%h want 0/1/c", use_flush, req1, vld1, pc1); else n_pass++;
      end
      if (c == 6) begin
        n_total++; if (req1 !== 1'b1 || addr1 !== tgt[11:2]) $display("FAIL redir_issue f=%0b got req=%0b addr=%h want 1/%h", use_flush, req1, addr1, tgt[11:2]); else n_pass++;
      end
      if (c == 6 || c == 7) begin
        n_total++; if (vld1 !== 1'b0 || cnt1 !== 3'd0) $display("FAIL redir_shadow f=%0b c=%0d got vld=%0b cnt=%0d want 0/0", use_flush, c, vld1, cnt1); else n_pass++;
      end
      if (c == 8 || c == 9) begin
        n_total++; if (vld1 !== 1'b1 || pc1 !== tgt + 32'(4 * (c - 8)) || ins1 !== (32'h1000_0000 | ((tgt >> 2) + 32'(c - 8))))
          $display("FAIL redir_target f=%0b c=%0d got vld=%0b pc=%h instr=%h want 1/%h", use_flush, c, vld1, pc1, ins1, tgt + 32'(4 * (c - 8))); else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_memlat2_wrap;
    logic [31:0] e;
    do_reset(1'b1);
    for (int c = 0; c < 15; c++) begin
      redir2 = (c == 9);
      redir_pc2 = (c == 9) ? 32'h3FC : 32'h0;
      @(negedge clk);
      if (c == 2) begin
        n_total++; if (vld2 !== 1'b0) $display("FAIL ml2_latency got vld=%0b want 0", vld2); else n_pass++;
      end
      if (c >= 3 && c <= 9) begin
        e = 32'(4 * (c - 3));
        n_total++; if (vld2 !== 1'b1 || pc2 !== e || ins2 !== (32'h1000_0000 | (e >> 2))) $display("FAIL ml2_stream c=%0d got vld=%0b pc=%h instr=%h want 1/%h", c, vld2, pc2, ins2, e); else n_pass++;
      end
      if (c == 10) begin
        n_total++; if (req2 !== 1'b1 || addr2 !== 8'hFF) $display("FAIL ml2_addr_ff got req=%0b addr=%h want 1/ff", req2, addr2); else n_pass++;
      end
      if (c == 11) begin
        n_total++; if (addr2 !== 8'h00) $display("FAIL ml2_addr_wrap got %h want 00", addr2); else n_pass++;
      end
      if (c >= 10 && c <= 12) begin
        n_total++; if (vld2 !== 1'b0) $display("FAIL ml2_shadow c=%0d got vld=%0b want 0", c, vld2); else n_pass++;
      end
      if (c == 13) begin
        n_total++; if (vld2 !== 1'b1 || pc2 !== 32'h3FC || ins2 !== 32'h1000_00FF) $display("FAIL ml2_wrap_a got vld=%0b pc=%h instr=%h want 1/3fc/100000ff", vld2, pc2, ins2); else n_pass++;
      end
      if (c == 14) begin
        n_total++; if (vld2 !== 1'b1 || pc2 !== 32'h400 || ins2 !== 32'h1000_0000) $display("FAIL ml2_wrap_b got vld=%0b pc=%h instr=%h want 1/400/10000000", vld2, pc2, ins2); else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_midstream;
    do_reset(1'b1);
    for (int c = 0; c < 11; c++) begin
      rst_n = (c != 6);
      @(negedge clk);
      if (c == 5) begin
        n_total++; if (vld1 !== 1'b1 || pc1 !== 32'hC) $display("FAIL mid_prestream got vld=%0b pc=%h want 1/c", vld1, pc1); else n_pass++;
      end
      if (c == 6) begin
        n_total++; if (req1 !== 1'b0) $display("FAIL mid_req_in_reset got %0b want 0", req1); else n_pass++;
      end
      if (c == 7) begin
        n_total++; if (vld1 !== 1'b0 || cnt1 !== 3'd0 || pc1 !== 32'h0) $display("FAIL mid_after_reset got vld=%0b cnt=%0d pc=%h want 0/0/0", vld1, cnt1, pc1); else n_pass++;
        n_total++; if (req1 !== 1'b1 || addr1 !== 10'd0) $display("FAIL mid_restart_req got req=%0b addr=%h want 1/0", req1, addr1); else n_pass++;
      end
      if (c == 8) begin
        n_total++; if (vld1 !== 1'b0) $display("FAIL mid_stale got vld=%0b pc=%h want 0", vld1, pc1); else n_pass++;
      end
      if (c == 9 || c == 10) begin
        n_total++; if (vld1 !== 1'b1 || pc1 !== 32'(4 * (c - 9)) || ins1 !== (32'h1000_0000 | 32'(c - 9))) $display("FAIL mid_restream c=%0d got vld=%0b pc=%h instr=%h", c, vld1, pc1, ins1); else n_pass++;
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect(1'b0);
    test_redirect(1'b1);
    test_memlat2_wrap();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
